set_assoc_cache_controller: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache controller.

---
 rtl/set_assoc_cache_controller_if.sv | 29 ++
 rtl/set_assoc_cache_controller.sv | 142 ++++++++++++++
 tb/tb_set_assoc_cache_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/set_assoc_cache_controller_if.sv
// set_assoc_cache_controller_if: CPU load/store port and word-wide memory port of the cache controller
interface set_assoc_cache_controller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_done;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  hit;
  logic                  miss;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_done, cpu_rdata, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_done, cpu_rdata, hit, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_controller.sv
// set_assoc_cache_controller: N-way set-associative write-back, write-allocate cache controller
// with per-set round-robin replacement, dirty writeback and variable-latency refill.
module set_assoc_cache_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int WAYS       = 2
) (
  input logic clk,
  input logic reset,
  set_assoc_cache_controller_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, RESPOND} state_t;
  state_t r_state, w_next;
  logic                  r_we;
  logic [ADDR_WIDTH-3:0] r_line;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [WAY_W-1:0]      r_victim;
  logic [WAYS-1:0]       r_valid [NUM_SETS];
  logic [WAYS-1:0]       r_dirty [NUM_SETS];
  logic [WAY_W-1:0]      r_rr    [NUM_SETS];
  logic [TAG_W-1:0]      r_tag   [NUM_SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][WAYS];
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hway, w_victim, w_rr_nxt;
  assign w_idx    = r_line[IDX_W-1:0];
  assign w_tag    = r_line[ADDR_WIDTH-3 -: TAG_W];
  assign w_rr_nxt = WAYS == 1 ? '0 : w_victim + WAY_W'(1);
  // Lowest invalid way wins; a fully valid set falls back to the round-robin pointer.
  always_comb begin
    w_hit    = 1'b0;
    w_hway   = '0;
    w_victim = r_rr[w_idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = WAY_W'(w);
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we     <= 1'b0;
      r_line   <= '0;
      r_wdata  <= '0;
      r_victim <= '0;
    end else begin
      if (r_state == IDLE && bus.cpu_req) begin
        r_we    <= bus.cpu_we;
        r_line  <= bus.cpu_addr[ADDR_WIDTH-1:2];
        r_wdata <= bus.cpu_wdata;
      end
      if (r_state == COMPARE && !w_hit) r_victim <= w_victim;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (r_state == COMPARE && w_hit && r_we) r_dirty[w_idx][w_hway] <= 1'b1;
      if (r_state == COMPARE && !w_hit) r_rr[w_idx] <= w_rr_nxt;
      if (r_state == REFILL && bus.mem_ack) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
      if (r_state == RESPOND && r_we) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b1;
      end
    end
  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (r_state == COMPARE && w_hit && r_we) r_data[w_idx][w_hway] <= r_wdata;
    if (r_state == REFILL && bus.mem_ack) begin
      r_data[w_idx][r_victim] <= bus.mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
    if (r_state == RESPOND && r_we) begin
      r_data[w_idx][r_victim] <= r_wdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end
  always_comb begin
    w_next        = r_state;
    bus.cpu_ready = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.cpu_rdata = '0;
    bus.hit       = 1'b0;
    bus.miss      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        w_next        = bus.cpu_req ? COMPARE : IDLE;
      end
      COMPARE: begin
        bus.hit  = w_hit;
        bus.miss = !w_hit;
        if (w_hit) begin
          bus.cpu_done  = 1'b1;
          bus.cpu_rdata = r_we ? r_wdata : r_data[w_idx][w_hway];
          w_next        = IDLE;
        end else
          w_next = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim] ? WRITEBACK :
                   r_we ? RESPOND : REFILL;
      end
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {r_tag[w_idx][r_victim], w_idx, 2'b00};
        bus.mem_wdata = r_data[w_idx][r_victim];
        w_next        = !bus.mem_ack ? WRITEBACK : r_we ? RESPOND : REFILL;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {w_tag, w_idx, 2'b00};
        w_next       = bus.mem_ack ? RESPOND : REFILL;
      end
      RESPOND: begin
        bus.cpu_done  = 1'b1;
        bus.cpu_rdata = r_we ? r_wdata : r_data[w_idx][r_victim];
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_set_assoc_cache_controller.sv
// tb_set_assoc_cache_controller: directed vector table for the 64-set 2-way cache controller,
// with the bench acting as CPU and as a variable-latency memory.
module tb_set_assoc_cache_controller;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_err = 0;
  set_assoc_cache_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  set_assoc_cache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SETS(64), .WAYS(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        rf;
    logic [31:0] rf_addr;
    logic [31:0] rf_data;
    int          delay;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic hit, input logic wb, input logic [31:0] wb_addr,
                              input logic [31:0] wb_data, input logic rf, input logic [31:0] rf_addr,
                              input logic [31:0] rf_data, input int delay, input logic chk_rd,
                              input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.hit = hit;
    v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.rf = rf; v.rf_addr = rf_addr; v.rf_data = rf_data;
    v.delay = delay; v.chk_rd = chk_rd; v.rdata = rdata;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  // One CPU request plus the memory side; acks each transfer after v.delay extra cycles.
  task automatic run(input vec_t v, input int k);
    int cnt, nx, cyc, n_exp;
    bit done, acked;
    n_exp = int'(v.wb) + int'(v.rf);
    @(negedge clk);
    chk($sformatf("v%0d ready", k), bus.cpu_ready, 1);
    bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = ~v.we; bus.cpu_addr = '1; bus.cpu_wdata = ~v.wdata;
    chk($sformatf("v%0d hit", k), bus.hit, v.hit);
    chk($sformatf("v%0d miss", k), bus.miss, !v.hit);
    chk($sformatf("v%0d busy", k), bus.cpu_ready, 0);
    cnt = 0; nx = 0; done = 0; acked = 0;
    for (cyc = 0; cyc < 40 && !done; cyc++) begin
      if (acked && nx == n_exp) chk($sformatf("v%0d mem_req drop", k), bus.mem_req, 0);
      acked = 0;
      if (bus.cpu_done) begin
        done = 1;
        if (v.hit) chk($sformatf("v%0d hit latency", k), cyc, 0);
        if (v.chk_rd) chk($sformatf("v%0d rdata", k), bus.cpu_rdata, v.rdata);
      end else if (bus.mem_req) begin
        if (cnt == 0) begin
          if (nx == 0 && v.wb) begin
            chk($sformatf("v%0d wb we", k), bus.mem_we, 1);
            chk($sformatf("v%0d wb addr", k), bus.mem_addr, v.wb_addr);
            chk($sformatf("v%0d wb data", k), bus.mem_wdata, v.wb_data);
          end else begin
            chk($sformatf("v%0d rf we", k), bus.mem_we, 0);
            chk($sformatf("v%0d rf addr", k), bus.mem_addr, v.rf_addr);
          end
          nx++;
        end
        if (cnt == v.delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = v.rf_data; cnt = 0; acked = 1;
        end else cnt++;
      end
      if (!done) begin
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A5A5A;
      end
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL v%0d timeout: got no cpu_done, expected one within 40 cycles", k);
    end
    chk($sformatf("v%0d transfers", k), nx, n_exp);
  endtask
  initial begin
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    //          we addr     wdata         hit wb wb_addr  wb_data       rf rf_addr  rf_data       dly chk rdata
    vt.push_back(mk(0, 'h010, 0,            0, 0, 0,     0,            1, 'h010, 'hDEADBEEF, 3, 1, 'hDEADBEEF));
    vt.push_back(mk(0, 'h010, 0,            1, 0, 0,     0,            0, 0,     0,          0, 1, 'hDEADBEEF));
    vt.push_back(mk(1, 'h110, 'hCAFEBABE,   0, 0, 0,     0,            0, 0,     0,          0, 1, 'hCAFEBABE));
    vt.push_back(mk(0, 'h110, 0,            1, 0, 0,     0,            0, 0,     0,          0, 1, 'hCAFEBABE));
    vt.push_back(mk(0, 'h210, 0,            0, 0, 0,     0,            1, 'h210, 'h0BADF00D, 1, 1, 'h0BADF00D));
    vt.push_back(mk(0, 'h010, 0,            0, 1, 'h110, 'hCAFEBABE,   1, 'h010, 'hDEADBEEF, 2, 1, 'hDEADBEEF));
    vt.push_back(mk(1, 'h210, 'h12345678,   1, 0, 0,     0,            0, 0,     0,          0, 0, 0));
    vt.push_back(mk(0, 'h210, 0,            1, 0, 0,     0,            0, 0,     0,          0, 1, 'h12345678));
    vt.push_back(mk(0, 'h310, 0,            0, 1, 'h210, 'h12345678,   1, 'h310, 'h31313131, 1, 1, 'h31313131));
    vt.push_back(mk(0, 'h410, 0,            0, 0, 0,     0,            1, 'h410, 'h44440000, 0, 1, 'h44440000));
    vt.push_back(mk(1, 'h024, 'h00000099,   0, 0, 0,     0,            0, 0,     0,          0, 1, 'h00000099));
    vt.push_back(mk(0, 'h027, 0,            1, 0, 0,     0,            0, 0,     0,          0, 1, 'h00000099));
    @(negedge clk);
    chk("reset ready", bus.cpu_ready, 1);
    chk("reset done", bus.cpu_done, 0);
    chk("reset hit/miss", {bus.hit, bus.miss}, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset rdata", bus.cpu_rdata, 0);
    reset = 1'b0;
    foreach (vt[i]) run(vt[i], i);
    // Reset in the middle of a refill: mem_req must fall without waiting for a clock.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 'h210;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
    chk("pre-reset refill req", bus.mem_req, 1);
    chk("pre-reset refill addr", bus.mem_addr, 'h210);
    #2 reset = 1'b1;
    #1 chk("async mem_req drop", bus.mem_req, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset ready", bus.cpu_ready, 1);
    run(mk(0, 'h210, 0, 0, 0, 0, 0, 1, 'h210, 'h22220000, 1, 1, 'h22220000), 100);
    run(mk(0, 'h010, 0, 0, 0, 0, 0, 1, 'h010, 'h10101010, 0, 1, 'h10101010), 101);
    run(mk(0, 'h210, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 'h22220000), 102);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
